// File: rtl/sa_job_sequencer_pkg.sv
// State encoding and array-bus address map for the systolic-array job sequencer.
package sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLR,
    ST_START,
    ST_WAIT,
    ST_RD,
    ST_FIN
  } state_e;

  localparam logic [7:0] REG_WEIGHT = 8'h00;
  localparam logic [7:0] REG_ACT    = 8'h40;
  localparam logic [7:0] REG_OUT    = 8'h80;
  localparam logic [7:0] REG_START  = 8'hC0;
  localparam logic [7:0] REG_STATUS = 8'h00;

  localparam int RD_HOLD    = 2;
  localparam int WAIT_GUARD = 2;

  function automatic logic [7:0] out_addr(input logic [5:0] idx);
    return REG_OUT | {2'b00, idx};
  endfunction

endpackage

// File: rtl/sa_job_sequencer_timer.sv
// Loadable, saturating down-counter shared by the WAIT guard/timeout and the RD hold.
module sa_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/sa_job_sequencer.sv
// Job sequencer: load weights/activations, clear outputs, start, poll, stream results.
// Optional build macro SA_JOB_SEQUENCER_TIMEOUT_EN adds a WAIT timeout with sticky err_o.
module sa_job_sequencer
  import sa_pkg::*;
#(
  parameter int MAC_W   = 19,
  parameter int X_W     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_vi,
  output logic             cmd_ready_o,
  input  logic [MAC_W-1:0] acc_init_i,
  output logic             src_rd_o,
  output logic [6:0]       src_addr_o,
  input  logic [X_W-1:0]   src_data_i,
  output logic [7:0]       arr_addr_o,
  output logic [31:0]      arr_data_o,
  output logic             arr_wr_vo,
  input  logic [MAC_W:0]   arr_data_i,
  output logic             res_vo,
  input  logic             res_ready_i,
  output logic [MAC_W:0]   res_data_o,
  output logic [5:0]       res_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

`ifdef SA_JOB_SEQUENCER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);
`else
  // TIMEOUT has no effect without the timeout option.
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_GUARD) | (8'(TIMEOUT) & 8'h00);
`endif
  localparam logic [7:0] GUARD_LIMIT = WAIT_LOAD - 8'(WAIT_GUARD);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [MAC_W-1:0] acc_q, acc_d;
  logic [5:0]       idx_q, idx_d;
  logic             res_v_q, res_v_d;
  logic [MAC_W:0]   res_data_q, res_data_d;
  logic             err_q, err_d;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [7:0]       tmr_load_val, tmr_cnt;
  logic [6:0]       load_k;

  sa_seq_timer #(.W(8)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .count_o    (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    res_v_d      = res_v_q;
    res_data_d   = res_data_q;
    err_d        = err_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    load_k       = cnt_q[6:0] - 7'd1;
    src_rd_o     = 1'b0;
    src_addr_o   = '0;
    arr_addr_o   = '0;
    arr_data_o   = '0;
    arr_wr_vo    = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_vi) begin
          acc_d   = acc_init_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Read k and write k-1 overlap; cnt runs 0..128 so the final write drains.
        src_rd_o   = ~cnt_q[7];
        src_addr_o = cnt_q[6:0];
        if (cnt_q != 8'd0) begin
          arr_wr_vo  = 1'b1;
          arr_addr_o = (load_k[6] ? REG_ACT : REG_WEIGHT) | {2'b00, load_k[5:0]};
          arr_data_o = 32'(src_data_i);
        end
        if (cnt_q == 8'd128) begin
          cnt_d   = '0;
          state_d = ST_CLR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CLR: begin
        arr_wr_vo  = 1'b1;
        arr_addr_o = REG_OUT | {2'b00, cnt_q[2:0], 3'b000};
        arr_data_o = 32'(acc_q);
        if (cnt_q[2:0] == 3'd7) begin
          cnt_d   = '0;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_START: begin
        arr_wr_vo    = 1'b1;
        arr_addr_o   = REG_START;
        tmr_load     = 1'b1;
        tmr_load_val = WAIT_LOAD;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        arr_addr_o = REG_STATUS;
        tmr_dec    = 1'b1;
        if ((tmr_cnt <= GUARD_LIMIT) && arr_data_i[0]) begin
          idx_d        = '0;
          res_v_d      = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = 8'(RD_HOLD - 1);
          state_d      = ST_RD;
        end
`ifdef SA_JOB_SEQUENCER_TIMEOUT_EN
        else if (tmr_zero) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
`endif
      end
      ST_RD: begin
        if (!res_v_q) begin
          arr_addr_o = out_addr(idx_q);
          if (tmr_zero) begin
            res_data_d = arr_data_i;
            res_v_d    = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end else if (res_ready_i) begin
          res_v_d = 1'b0;
          if (idx_q == 6'd63) begin
            state_d = ST_FIN;
          end else begin
            idx_d        = idx_q + 6'd1;
            tmr_load     = 1'b1;
            tmr_load_val = 8'(RD_HOLD - 1);
          end
        end
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      res_v_q    <= 1'b0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      res_v_q    <= res_v_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign res_vo      = res_v_q;
  assign res_data_o  = res_v_q ? res_data_q : '0;
  assign res_idx_o   = res_v_q ? idx_q : '0;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sa_job_sequencer.sv
// Randomized bench for sa_job_sequencer against a cycle-level job model.
module tb_sa_job_sequencer;

  localparam int MAC_W   = 19;
  localparam int X_W     = 8;
  localparam int TIMEOUT = 255;
  localparam int DW      = MAC_W + 1;
`ifdef SA_JOB_SEQUENCER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             cmd_vi = 1'b0;
  logic             cmd_ready_o;
  logic [MAC_W-1:0] acc_init_i = '0;
  logic             src_rd_o;
  logic [6:0]       src_addr_o;
  logic [X_W-1:0]   src_data_i = '0;
  logic [7:0]       arr_addr_o;
  logic [31:0]      arr_data_o;
  logic             arr_wr_vo;
  logic [DW-1:0]    arr_data_i;
  logic             res_vo;
  logic             res_ready_i = 1'b0;
  logic [DW-1:0]    res_data_o;
  logic [5:0]       res_idx_o;
  logic             busy_o, done_o, err_o;

  always #5 clk_i = ~clk_i;

  sa_job_sequencer #(.MAC_W(MAC_W), .X_W(X_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_vi(cmd_vi), .cmd_ready_o(cmd_ready_o),
    .acc_init_i(acc_init_i), .src_rd_o(src_rd_o), .src_addr_o(src_addr_o),
    .src_data_i(src_data_i), .arr_addr_o(arr_addr_o), .arr_data_o(arr_data_o),
    .arr_wr_vo(arr_wr_vo), .arr_data_i(arr_data_i), .res_vo(res_vo),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_idx_o(res_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Environment: source buffer and array (result = idx*mult, status on bit 0).
  logic [X_W-1:0] mem [128];
  int  job_mult    = 1;
  int  job_done_at = 3;
  bit  guard_noise = 1'b0;
  bit  status_bit  = 1'b0;
  logic [6:0] prev_src = '0;

  assign arr_data_i = (arr_addr_o[7:6] == 2'b10) ? DW'(int'(arr_addr_o[5:0]) * job_mult)
                                                 : DW'(status_bit);

  // Job model: phase plus cycle/index counters describing the current cycle.
  typedef enum int {P_IDLE, P_SEQ, P_WAIT, P_RD, P_FIN} phase_t;
  phase_t ph = P_IDLE;
  int t = 0, wc = 0, ridx = 0, rsub = 0, m_acc = 0;
  bit m_err = 1'b0;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_load_wr = 0, first_wr = -1, last_load_wr = -1, start_cyc = -1;
  int n_clr = 0, clr_data = -1, n_res = 0, order_bad = 0, done_cnt = 0, fin_cyc = -1;
  int last_res = -1, res_sum = 0, hold17 = 0, hold17_seen = 0, accept_steps = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic stats_clear();
    cyc = 0; n_load_wr = 0; first_wr = -1; last_load_wr = -1; start_cyc = -1;
    n_clr = 0; clr_data = -1; n_res = 0; order_bad = 0; done_cnt = 0; fin_cyc = -1;
    last_res = -1; res_sum = 0; hold17_seen = 0;
  endtask

  task automatic compare();
    bit e_rd, e_wr, a_chk, e_rv, e_done;
    int e_sa, e_addr, e_data, e_rdat, e_ridx;
    e_rd = 0; e_wr = 0; a_chk = 0; e_rv = 0; e_done = 0;
    e_sa = 0; e_addr = 0; e_data = 0; e_rdat = 0; e_ridx = 0;
    case (ph)
      P_SEQ: begin
        if (t <= 129) begin
          if (t <= 128) begin e_rd = 1; e_sa = t - 1; end
          if (t >= 2) begin e_wr = 1; e_addr = t - 2; e_data = int'(mem[7'(t - 2)]); end
        end else if (t <= 137) begin
          e_wr = 1; e_addr = 128 + 8 * (t - 130); e_data = m_acc;
        end else begin
          e_wr = 1; e_addr = 192; e_data = 0;
        end
      end
      P_WAIT: begin a_chk = 1; e_addr = 0; end
      P_RD: begin
        if (rsub < 2) begin
          a_chk = 1; e_addr = 128 + ridx;
        end else begin
          e_rv = 1; e_rdat = ridx * job_mult; e_ridx = ridx;
          chk("no_early_read", int'(arr_addr_o == 8'(128 + ridx + 1)), 0);
        end
      end
      P_FIN: e_done = 1;
      default: ;
    endcase
    chk("cmd_ready", int'(cmd_ready_o), int'(ph == P_IDLE));
    chk("busy", int'(busy_o), int'(ph != P_IDLE));
    chk("src_rd", int'(src_rd_o), int'(e_rd));
    if (e_rd) chk("src_addr", int'(src_addr_o), e_sa);
    chk("arr_wr", int'(arr_wr_vo), int'(e_wr));
    if (e_wr || a_chk) chk("arr_addr", int'(arr_addr_o), e_addr);
    chk("arr_data", int'(arr_data_o), e_data);
    chk("res_vo", int'(res_vo), int'(e_rv));
    if (e_rv) begin
      chk("res_data", int'(res_data_o), e_rdat);
      chk("res_idx", int'(res_idx_o), e_ridx);
    end
    chk("done", int'(done_o), int'(e_done));
    chk("err", int'(err_o), int'(m_err));
  endtask

  task automatic record();
    if (arr_wr_vo) begin
      if (arr_addr_o < 8'h80) begin
        n_load_wr++;
        if (first_wr < 0) first_wr = cyc;
        last_load_wr = cyc;
      end else if (arr_addr_o == 8'hC0) begin
        start_cyc = cyc;
      end else begin
        n_clr++; clr_data = int'(arr_data_o);
      end
    end
    if (res_vo && res_ready_i) begin
      if (int'(res_idx_o) != n_res) order_bad++;
      n_res++; last_res = int'(res_data_o); res_sum += int'(res_data_o);
    end
    if (res_vo && res_idx_o == 6'd17) hold17_seen++;
    if (done_o) begin done_cnt++; fin_cyc = cyc; end
  endtask

  task automatic advance(input bit cmd, input bit rdy, input bit st);
    case (ph)
      P_IDLE: if (cmd) begin
        ph = P_SEQ; t = 1; m_acc = int'(acc_init_i); m_err = 0; stats_clear();
      end
      P_SEQ: begin
        t++;
        if (t == 139) begin ph = P_WAIT; wc = 1; end
      end
      P_WAIT: begin
        if (wc >= 3 && st) begin ph = P_RD; ridx = 0; rsub = 0; end
        else if (TO_EN && wc == TIMEOUT) begin ph = P_FIN; m_err = 1; end
        else wc++;
      end
      P_RD: begin
        if (rsub < 2) rsub++;
        else if (rdy) begin
          if (ridx == 63) ph = P_FIN;
          else begin ridx++; rsub = 0; end
        end
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic cycle_step(input bit cmd, input bit rdy, input logic [MAC_W-1:0] acc);
    @(posedge clk_i);
    #1;
    cmd_vi = cmd; res_ready_i = rdy; acc_init_i = acc; src_data_i = mem[prev_src];
    status_bit = (ph == P_WAIT) &&
                 ((job_done_at != 0 && wc >= job_done_at) || (wc < 3 && guard_noise));
    #1;
    compare();
    record();
    prev_src = src_addr_o;
    advance(cmd, rdy, status_bit);
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle_step(1'b0, 1'($urandom_range(0, 1)), '0);
  endtask

  task automatic run_job(input logic [MAC_W-1:0] acc, input int mult, input int done_at,
                         input bit noise, input bit rnd_rdy, input bit stall17, input int rst_at);
    int budget;
    bit started, cmd, rdy;
    job_mult = mult; job_done_at = done_at; guard_noise = noise; hold17 = 0;
    budget = 2000; started = 0; accept_steps = 0;
    while ((!started || ph != P_IDLE) && budget > 0) begin
      cmd = !started || ($urandom_range(0, 3) == 0);
      rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall17 && ph == P_RD && ridx == 17 && rsub == 2) begin
        rdy = (hold17 >= 10); hold17++;
      end
      if (!started) accept_steps++;
      cycle_step(cmd, rdy, started ? MAC_W'($urandom_range(0, (1 << MAC_W) - 1)) : acc);
      if (ph != P_IDLE) started = 1;
      if (rst_at > 0 && ph == P_SEQ && t == rst_at + 1) begin
        #1 rst_i = 1'b0;
        #1 ph = P_IDLE; m_err = 0;
        for (int i = 0; i < 3; i++) cycle_step(1'b0, 1'b0, '0);
        #1 rst_i = 1'b1;
      end
      budget--;
    end
    chk("job_within_budget", int'(budget > 0), 1);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 128; k++) mem[k] = X_W'($urandom);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = '0;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_cmd_ready", int'(cmd_ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_res_vo", int'(res_vo), 0);
    chk("rst_arr_wr", int'(arr_wr_vo), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_done", int'(done_o), 0);
    #1 rst_i = 1'b1;
    idle_cycles(20);

    // Ramp source data, acc_init 5, status at WAIT cycle 3, results idx*3.
    for (int k = 0; k < 128; k++) mem[k] = X_W'(k);
    run_job(MAC_W'(5), 3, 3, 1'b0, 1'b0, 1'b0, 0);
    chk("j1_load_writes", n_load_wr, 128);
    chk("j1_first_write_cycle", first_wr, 2);
    chk("j1_last_load_cycle", last_load_wr, 129);
    chk("j1_clr_writes", n_clr, 8);
    chk("j1_clr_data", clr_data, 5);
    chk("j1_start_cycle", start_cyc, 138);
    chk("j1_results", n_res, 64);
    chk("j1_last_result", last_res, 189);
    chk("j1_result_sum", res_sum, 6048);
    chk("j1_order", order_bad, 0);
    chk("j1_done_pulses", done_cnt, 1);

    // Random data, early status noise, random ready, stall at idx 17.
    fill_random();
    run_job(MAC_W'($urandom_range(0, (1 << MAC_W) - 1)), int'($urandom_range(1, 1000)),
            int'($urandom_range(3, 12)), 1'b1, 1'b1, 1'b1, 0);
    chk("j2_idx17_hold_cycles", hold17_seen, 11);
    chk("j2_results", n_res, 64);
    chk("j2_order", order_bad, 0);
    chk("j2_done_pulses", done_cnt, 1);

    // Back-to-back: the cycle after FIN accepts a new command.
    fill_random();
    run_job(MAC_W'($urandom_range(0, (1 << MAC_W) - 1)), int'($urandom_range(1, 1000)),
            int'($urandom_range(3, 8)), 1'b1, 1'b1, 1'b0, 0);
    chk("j3_b2b_accept_steps", accept_steps, 1);
    chk("j3_results", n_res, 64);

    // Reset in LOAD cycle 50, then quiet bus and a clean job.
    fill_random();
    run_job(MAC_W'($urandom_range(0, (1 << MAC_W) - 1)), 7, 5, 1'b0, 1'b1, 1'b0, 50);
    idle_cycles(20);
    chk("j4_load_writes_before_reset", n_load_wr, 49);
    chk("j4_no_done", done_cnt, 0);
    chk("j4_no_results", n_res, 0);
    fill_random();
    run_job(MAC_W'($urandom_range(0, (1 << MAC_W) - 1)), int'($urandom_range(1, 1000)),
            int'($urandom_range(3, 12)), 1'b1, 1'b1, 1'b0, 0);
    chk("j5_results", n_res, 64);
    chk("j5_done_pulses", done_cnt, 1);

`ifdef SA_JOB_SEQUENCER_TIMEOUT_EN
    // Status never rises: timeout after TIMEOUT WAIT cycles, no results.
    run_job(MAC_W'(9), 1, 0, 1'b0, 1'b1, 1'b0, 0);
    idle_cycles(1);
    chk("to_err_sticky", int'(err_o), 1);
    chk("to_done_pulses", done_cnt, 1);
    chk("to_fin_cycle", fin_cyc, 139 + TIMEOUT);
    chk("to_no_results", n_res, 0);
    run_job(MAC_W'(9), 2, 4, 1'b0, 1'b1, 1'b0, 0);
    chk("to_err_cleared", int'(err_o), 0);
    chk("to_next_results", n_res, 64);
`endif

    idle_cycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_job_sequencer.md
# sa_job_sequencer

Host-side job sequencer for the 8x8 systolic-array subsystem. It takes one job command and runs it end to end over the array's shared 8-bit address / 32-bit data bus:
- copy 64 weights and 64 activations from a source buffer;
- initialise the 8 output buffers;
- start the array, then poll its status until idle;
- stream the 64 results out through a valid/ready port.

It sits between the system front end and the array top, and is the only master of the array bus.

## Interface
- MAC_W, 19: accumulator width; array read data is MAC_W+1 bits.
- X_W, 8: weight/activation width.
- TIMEOUT, 255: maximum poll cycles in WAIT before aborting.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- cmd_vi  in  1  job request.
- cmd_ready_o  out  1  high only in IDLE.
- acc_init_i  in  MAC_W  accumulator initial value, sampled at command accept.
- src_rd_o  out  1  source buffer read strobe.
- src_addr_o  out  7  source address; 0-63 are weights, 64-127 are activations.
- src_data_i  in  X_W  source read data, valid 1 cycle after src_rd_o.
- arr_addr_o  out  8  array bus address.
- arr_data_o  out  32  array bus write data.
- arr_wr_vo  out  1  array bus write strobe.
- arr_data_i  in  MAC_W+1  array read data.
- res_vo  out  1  result valid.
- res_ready_i  in  1  result accept.
- res_data_o  out  MAC_W+1  result value.
- res_idx_o  out  6  result index; [5:3] is the column, [2:0] is the entry.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a job finishes.
- err_o  out  1  sticky timeout flag; cleared at the next command accept.

## Operation
- States, in order: IDLE, LOAD, CLR, START, WAIT, RD, FIN.
- IDLE: a command is accepted when cmd_vi and cmd_ready_o are both high. acc_init_i is latched and the state moves to LOAD.
- LOAD: 128 source reads are issued on consecutive cycles, k = 0..127 (src_addr_o = k).
  - Each read is followed, one cycle later, by an array write: arr_addr_o = k, arr_data_o = zero-extended src_data_i.
  - The last write happens in the cycle after the last read; LOAD then exits.
- CLR: 8 writes, j = 0..7, with arr_addr_o = 0x80 | (j<<3) and arr_data_o = zero-extended latched acc_init.
- START: one write to address 0xC0. Data is 0.
- WAIT: arr_addr_o = 0x00, arr_wr_vo = 0.
  - arr_data_i[0] is ignored during the first 2 WAIT cycles.
  - From the 3rd WAIT cycle onward, arr_data_i[0] == 1 means the array is done; go to RD.
- RD: for each idx = 0..63:
  - Hold arr_addr_o = 0x80 | idx for 2 cycles and capture arr_data_i on the 2nd cycle.
  - Then assert res_vo with the captured value and idx.
  - Hold res_vo, res_data_o and res_idx_o stable until res_ready_i is high.
  - After the handshake, move to the next idx. The handshake for idx 63 moves the state to FIN.
- FIN: done_o = 1 for one cycle, then IDLE.
- Bus idle rule: arr_wr_vo = 0 and src_rd_o = 0 in every cycle not listed above. arr_data_o = 0 whenever no write is issued.
- cmd_vi while busy is ignored; commands are not queued.

## Timing
- Reset values: every output 0 except cmd_ready_o = 1; state is IDLE.
- Reset asserted mid-job: the job is abandoned immediately. No further bus activity occurs and err_o is not set.
- Cycle budget with command accepted at cycle 0 (edge 0):
  - LOAD occupies cycles 1-129.
  - CLR occupies cycles 130-137.
  - START write is at cycle 138.
  - WAIT begins at cycle 139.
- Minimum RD time is 3 cycles per result (2 read cycles plus 1 handshake cycle). res_vo may be high in the capture+1 cycle at the earliest.
- res_ready_i high before res_vo has no effect.
- The cycle after FIN, cmd_ready_o = 1; a new command may be accepted in that cycle.

## Configuration
- SA_JOB_SEQUENCER_TIMEOUT_EN defined:
  - A WAIT cycle counter runs. If it reaches TIMEOUT without done, err_o is set and the state goes to FIN.
  - The RD phase is skipped; done_o still pulses.
- SA_JOB_SEQUENCER_TIMEOUT_EN undefined:
  - WAIT polls indefinitely. err_o is tied to 0 and the TIMEOUT parameter is unused.

## Structure
- Package sa_pkg holds:
  - the state enum;
  - region constants: weight 0x00, activation 0x40, output 0x80, start 0xC0;
  - the status poll address;
  - the RD_HOLD = 2 constant.
- One sub-module is natural: sa_seq_timer, a loadable down-counter. It is shared by the WAIT guard/timeout and the RD hold count.

## Test plan
- Reset then idle: cmd_ready_o = 1; busy_o, res_vo, arr_wr_vo and err_o all 0; the bus stays quiet for 20 cycles.
- Source buffer loaded with value k at address k, acc_init = 5, status high at WAIT cycle 3:
  - expect 128 writes (address k, data k) in cycles 2-129;
  - expect 8 CLR writes with data 5;
  - expect the start write at cycle 138.
- Array model returns idx*3 for reads at 0x80|idx, res_ready_i tied high: expect 64 results in index order with values 0, 3, …, 189, then done_o pulses once.
- res_ready_i low for 10 cycles at idx 17: res_vo, res_data_o and res_idx_o are held stable; no 0x80|18 read starts before the handshake.
- With SA_JOB_SEQUENCER_TIMEOUT_EN and TIMEOUT = 255, status never high: err_o is set after 255 WAIT cycles, done_o pulses, no res_vo. The next command clears err_o.
- Reset asserted at LOAD cycle 50 and released: IDLE with no further writes; a new job then completes normally.
